// File: rtl/snax_acc_launch_ctrl.sv
// Accelerator launch controller: one-deep CSR shadow feeding an active config dispatched to NumUnits sub-units.
// Launch at t shows first unit_cfg_valid_o at t+2; csr_reg_set_ready_o drops while the shadow is full.
module snax_acc_launch_ctrl #(
  parameter int unsigned RegRWCount   = 10,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned NumUnits     = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [RegRWCount-1:0][RegDataWidth-1:0]   csr_reg_set_i,
  input  logic                                      csr_reg_set_valid_i,
  output logic                                      csr_reg_set_ready_o,
  output logic [2:0][RegDataWidth-1:0]              csr_reg_ro_set_o,
  output logic [RegRWCount-1:0][RegDataWidth-1:0]   unit_cfg_o,
  output logic [NumUnits-1:0]                       unit_cfg_valid_o,
  input  logic [NumUnits-1:0]                       unit_cfg_ready_i,
  input  logic [NumUnits-1:0]                       unit_done_i
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDispatch = 2'd1;
  localparam logic [1:0] StRun      = 2'd2;

  typedef logic [RegRWCount-1:0][RegDataWidth-1:0] cfg_t;

  logic [1:0]              state_q, state_d;
  cfg_t                    shadow_q, shadow_d;
  cfg_t                    active_q, active_d;
  logic                    shadow_valid_q, shadow_valid_d;
  logic [NumUnits-1:0]     accepted_q, accepted_d;
  logic [NumUnits-1:0]     done_q, done_d;
  logic [RegDataWidth-1:0] perf_q, perf_d;
  logic [RegDataWidth-1:0] opcount_q, opcount_d;

  logic [NumUnits-1:0] active_en, shadow_en, accept, done_set, run_mask;
  logic                in_op, launch, accepted_all, done_all;

  assign active_en = active_q[RegRWCount-1][NumUnits-1:0];
  assign shadow_en = shadow_q[RegRWCount-1][NumUnits-1:0];
  assign in_op     = (state_q == StDispatch) || (state_q == StRun);
  assign launch    = csr_reg_set_valid_i & ~shadow_valid_q;

  assign csr_reg_set_ready_o = ~shadow_valid_q;
  assign unit_cfg_o          = active_q;
  assign unit_cfg_valid_o    = (state_q == StDispatch) ? (active_en & ~accepted_q) : '0;

  // A done pulse counts only once its unit has been handed the config, even in the same cycle.
  assign accept       = unit_cfg_valid_o & unit_cfg_ready_i;
  assign done_set     = unit_done_i & active_en & (accepted_q | accept) & {NumUnits{in_op}};
  assign accepted_all = (((accepted_q | accept) & active_en) == active_en);
  assign done_all     = (((done_q | done_set) & active_en) == active_en);

  assign run_mask = in_op ? (active_en & ~done_q) : '0;
  assign csr_reg_ro_set_o[0] = (RegDataWidth'(run_mask) << 2)
                             | RegDataWidth'({shadow_valid_q, in_op | shadow_valid_q});
  assign csr_reg_ro_set_o[1] = perf_q;
  assign csr_reg_ro_set_o[2] = opcount_q;

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    shadow_valid_d = shadow_valid_q;
    accepted_d     = accepted_q | accept;
    done_d         = done_q | done_set;
    perf_d         = perf_q;
    opcount_d      = opcount_q;

    if (launch) begin
      shadow_d       = csr_reg_set_i;
      shadow_valid_d = 1'b1;
    end

    if (in_op && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (shadow_valid_q) begin
          active_d       = shadow_q;
          shadow_valid_d = 1'b0;
          accepted_d     = '0;
          done_d         = '0;
          perf_d         = '0;
          if (shadow_en == '0) begin
            opcount_d = opcount_q + 1'b1;
          end else begin
            state_d = StDispatch;
          end
        end
      end
      StDispatch: begin
        if (accepted_all) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (done_all) begin
          state_d   = StIdle;
          opcount_d = opcount_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      shadow_q       <= '0;
      active_q       <= '0;
      shadow_valid_q <= 1'b0;
      accepted_q     <= '0;
      done_q         <= '0;
      perf_q         <= '0;
      opcount_q      <= '0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      shadow_valid_q <= shadow_valid_d;
      accepted_q     <= accepted_d;
      done_q         <= done_d;
      perf_q         <= perf_d;
      opcount_q      <= opcount_d;
    end
  end

endmodule
